// File: rtl/alu_exec_unit_if.sv
// Command/result handshake bundle between decode, the execute unit and writeback.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUctrl;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, ALUctrl, srcA, srcB, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, ALUctrl, srcA, srcB, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: single-cycle logic/arithmetic, bit-serial shifts,
// registered result and zero flag behind valid/ready handshakes.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst_n,
  alu_exec_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL
  } op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic             is_shift;
  logic [SHW-1:0]   shamt;
  logic [SHW-1:0]   cnt;
  logic             shift_left;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] alu_val;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  // Command decode
  always_comb begin
    op       = op_t'(bus.ALUctrl);
    is_shift = (op == OP_SLL) || (op == OP_SRL);
    shamt    = bus.srcB[SHW-1:0];
  end

  // Single-cycle operations; a shift by zero passes srcA through
  always_comb begin
    alu_val = '0;
    case (op)
      OP_ADD:  alu_val = bus.srcA + bus.srcB;
      OP_SUB:  alu_val = bus.srcA - bus.srcB;
      OP_AND:  alu_val = bus.srcA & bus.srcB;
      OP_OR:   alu_val = bus.srcA | bus.srcB;
      OP_XOR:  alu_val = bus.srcA ^ bus.srcB;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
      default: alu_val = bus.srcA;
    endcase
  end

  // One-bit step of the serial shifter
  always_comb begin
    shreg_nxt = shift_left ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt == SHW'(1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shifting and result registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_shift && shamt != '0) begin
              shreg      <= bus.srcA;
              cnt        <= shamt;
              shift_left <= (op == OP_SLL);
            end else begin
              result_q <= alu_val;
              zero_q   <= (alu_val == '0);
            end
          end
        end
        SHIFT: begin
          shreg <= shreg_nxt;
          cnt   <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result_q <= shreg_nxt;
            zero_q   <= (shreg_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random commands
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
    return (op >= 3'd6) ? int'(b % 32) + 1 : 1;
  endfunction

  // Called at a negedge with the unit idle; returns just after the accept edge.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    check({tag, ".in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.ALUctrl  = op;
    bus.srcA     = a;
    bus.srcB     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.srcA     = $urandom;
    bus.srcB     = $urandom;
  endtask

  // Waits (bounded) for out_valid and checks latency, result and zero; ends at a negedge.
  task automatic await_result(input string tag, input logic [31:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".result"}, bus.result, exp);
    check({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, (exp == 32'd0)});
  endtask

  task automatic drain(input string tag, input logic [31:0] exp);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".drained"}, {31'b0, bus.out_valid}, 32'd0);
    check({tag, ".held"}, bus.result, exp);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    exp = ref_alu(op, a, b);
    issue(tag, op, a, b);
    await_result(tag, exp, ref_lat(op, b));
    drain(tag, exp);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ALUctrl   = '0;
    bus.srcA      = '0;
    bus.srcB      = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst.result", bus.result, 32'd0);
    check("rst.zero", {31'b0, bus.zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);

    run("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1);
    run("sub_neg",  3'd1, 32'd5, 32'd7);
    run("slt_neg",  3'd5, 32'hFFFF_FFFF, 32'd1);
    run("slt_swap", 3'd5, 32'd1, 32'hFFFF_FFFF);
    run("sll_31",   3'd6, 32'd1, 32'h0000_003F);
    run("srl_4",    3'd7, 32'h8000_0000, 32'd4);
    run("sll_0",    3'd6, 32'h1234_5678, 32'hFFFF_FFE0);
    run("srl_0",    3'd7, 32'h8765_4321, 32'd0);
    run("and",      3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run("or",       3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run("xor_zero", 3'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA);

    // Backpressure: hold the result while a second command waits upstream
    issue("stall", 3'd0, 32'd3, 32'd4);
    await_result("stall", 32'd7, 1);
    bus.in_valid = 1'b1;
    bus.ALUctrl  = 3'd4;
    bus.srcA     = 32'h55;
    bus.srcB     = 32'h0F;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall.out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("stall.in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("stall.result", bus.result, 32'd7);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("stall.accept_next", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    await_result("second", 32'h5A, 1);
    drain("second", 32'h5A);

    // Reset in the middle of a long shift aborts it
    issue("rst_shift", 3'd6, 32'd1, 32'd20);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_shift.out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_shift.result", bus.result, 32'd0);
    check("rst_shift.zero", {31'b0, bus.zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_shift.in_ready", {31'b0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst_shift.no_stale", seen, 0);

    // Random commands against the reference model
    for (int unsigned i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b = b & 32'h1F;
      run("rand", op, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
